// File: rtl/regfile_pkg.sv
// regfile_pkg: shared scan FSM state type and default sizes for regfile_scan
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 8;
  typedef enum logic [1:0] {IDLE, PRESENT, DONE} scan_state_t;
endpackage

// File: rtl/regfile_scan_ctrl.sv
// regfile_scan_ctrl: scan FSM, beat index counter and valid/ready handshake
module regfile_scan_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          ready_i,
  output logic [AW-1:0] idx_o,
  output logic [AW-1:0] idx_nxt_o,
  output logic          load_o,
  output logic          valid_o,
  output logic          busy_o,
  output logic          done_o
);
  scan_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_o  = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = PRESENT;
        idx_d   = '0;
        load_o  = 1'b1;
      end
      PRESENT: if (ready_i) begin
        if (idx_q == AW'(NUM_REGS - 1)) state_d = DONE;
        else begin
          idx_d  = idx_q + 1'b1;
          load_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    idx_q   <= rst ? '0 : idx_d;
  end
  assign idx_o     = idx_q;
  assign idx_nxt_o = idx_d;
  assign valid_o   = state_q == PRESENT;
  assign busy_o    = state_q != IDLE;
  assign done_o    = state_q == DONE;
endmodule

// File: rtl/regfile_scan.sv
// regfile_scan: register file (r0 = 0) with NUM_RD async read ports and a streaming scan port.
// Optional same-cycle write-to-read forwarding: define REGFILE_WR_BYPASS_EN.
module regfile_scan
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  input  logic                     scan_start,
  input  logic                     scan_ready,
  output logic                     scan_valid,
  output logic [AW-1:0]            scan_idx,
  output logic [DATA_W-1:0]        scan_data,
  output logic                     scan_busy,
  output logic                     scan_done
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] scan_data_q;
  logic [AW-1:0]     idx_nxt;
  logic              load;
  regfile_scan_ctrl #(.NUM_REGS(NUM_REGS)) u_ctrl (
    .clk       (CLOCK_50),
    .rst       (reset),
    .start_i   (scan_start),
    .ready_i   (scan_ready),
    .idx_o     (scan_idx),
    .idx_nxt_o (idx_nxt),
    .load_o    (load),
    .valid_o   (scan_valid),
    .busy_o    (scan_busy),
    .done_o    (scan_done)
  );
  // Capture reads the pre-edge contents, so a same-edge write is not seen by this beat
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      scan_data_q <= '0;
    end else begin
      if (we && wa != '0) regs_q[wa] <= wd;
      if (load) scan_data_q <= regs_q[idx_nxt];
    end
  end
  assign scan_data = scan_data_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];
`ifdef REGFILE_WR_BYPASS_EN
    assign rd[k*DATA_W +: DATA_W] = (we && wa != '0 && ra_k == wa) ? wd : regs_q[ra_k];
`else
    assign rd[k*DATA_W +: DATA_W] = regs_q[ra_k];
`endif
  end
endmodule
